alarma: RTL and testbench

- Alarm block of the alarm-clock design; consumes the BCD time digits (HH:MM) produced by the time-keeping counter.
- Holds a user-settable BCD alarm time, edited with minute/hour pushbuttons while in alarm-set mode.
- Compares the alarm time with the current time and runs a ring/snooze state machine.
- Drives a beeping buzzer output.

---
 rtl/alarma.sv | 157 +++++++++++++++
 tb/tb_alarma.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarma.sv
// Alarm block: a user-settable BCD alarm time, an edge-triggered match against
// the current time, and a ring/snooze state machine that drives a beeping buzzer.
module alarma #(
  parameter int T_SONAR    = 60,
  parameter int T_POSPONER = 300,
  parameter int CNT_W      = 9
) (
  input  logic       reloj,
  input  logic       reset,
  input  logic [3:0] c0,
  input  logic [3:0] c1,
  input  logic [3:0] c2,
  input  logic [3:0] c3,
  input  logic       buttonalarma,
  input  logic       pulm,
  input  logic       pulh,
  input  logic       activar,
  input  logic       snooze,
  input  logic       tick_seg,
  output logic [3:0] a0,
  output logic [3:0] a1,
  output logic [3:0] a2,
  output logic [3:0] a3,
  output logic       sonando,
  output logic       pospuesta,
  output logic       buzzer
);

  typedef enum logic [1:0] {INACTIVA, ESPERA, SONANDO, POSPUESTA} estado_t;

  localparam logic [CNT_W-1:0] CNT_UNO     = CNT_W'(1);
  localparam logic [CNT_W-1:0] FIN_SONAR   = CNT_W'(T_SONAR - 1);
  localparam logic [CNT_W-1:0] FIN_POSPONE = CNT_W'(T_POSPONER - 1);

  estado_t          estado, estado_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             buzz_q, buzz_d;
  logic             pulm_q, pulh_q, snooze_q, eq_q;
  logic             pulm_e, pulh_e, snooze_e;
  logic             eq, fire;

  assign pulm_e   = pulm & ~pulm_q;
  assign pulh_e   = pulh & ~pulh_q;
  assign snooze_e = snooze & ~snooze_q;

  assign eq   = ({c3, c2, c1, c0} == {a3, a2, a1, a0});
  assign fire = eq & ~eq_q & ~buttonalarma;

  // eq_q starts at 1 so a 00:00 clock at reset release is not a fresh match.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      pulm_q   <= 1'b0;
      pulh_q   <= 1'b0;
      snooze_q <= 1'b0;
      eq_q     <= 1'b1;
    end else begin
      pulm_q   <= pulm;
      pulh_q   <= pulh;
      snooze_q <= snooze;
      eq_q     <= eq;
    end
  end

  // Minutes and hours wrap independently; a simultaneous hour press loses to minutes.
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      a0 <= 4'd0;
      a1 <= 4'd0;
      a2 <= 4'd0;
      a3 <= 4'd0;
    end else if (buttonalarma) begin
      if (pulm_e) begin
        if (a0 == 4'd9) begin
          a0 <= 4'd0;
          a1 <= (a1 == 4'd5) ? 4'd0 : a1 + 4'd1;
        end else begin
          a0 <= a0 + 4'd1;
        end
      end else if (pulh_e) begin
        if (a3 == 4'd2 && a2 == 4'd3) begin
          a3 <= 4'd0;
          a2 <= 4'd0;
        end else if (a2 == 4'd9) begin
          a2 <= 4'd0;
          a3 <= a3 + 4'd1;
        end else begin
          a2 <= a2 + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      estado <= INACTIVA;
      cnt    <= '0;
      buzz_q <= 1'b0;
    end else begin
      estado <= estado_d;
      cnt    <= cnt_d;
      buzz_q <= buzz_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    estado_d = estado;
    cnt_d    = cnt;
    buzz_d   = buzz_q;
    if (!activar) begin
      estado_d = INACTIVA;
    end else begin
      unique case (estado)
        INACTIVA: estado_d = ESPERA;
        ESPERA: begin
          if (fire) begin
            estado_d = SONANDO;
            cnt_d    = '0;
            buzz_d   = 1'b1;
          end
        end
        SONANDO: begin
          if (buttonalarma) begin
            estado_d = ESPERA;
          end else if (snooze_e) begin
            estado_d = POSPUESTA;
            cnt_d    = '0;
          end else if (tick_seg) begin
            cnt_d  = cnt + CNT_UNO;
            buzz_d = ~buzz_q;
            if (cnt == FIN_SONAR) estado_d = ESPERA;
          end
        end
        POSPUESTA: begin
          if (buttonalarma) begin
            estado_d = ESPERA;
          end else if (tick_seg) begin
            if (cnt == FIN_POSPONE) begin
              estado_d = SONANDO;
              cnt_d    = '0;
              buzz_d   = 1'b1;
            end else begin
              cnt_d = cnt + CNT_UNO;
            end
          end
        end
        default: estado_d = INACTIVA;
      endcase
    end
  end

  assign sonando   = (estado == SONANDO);
  assign pospuesta = (estado == POSPUESTA);
  assign buzzer    = sonando & buzz_q;

endmodule

// File: tb/tb_alarma.sv
// Self-checking bench for alarma: directed scenarios plus randomized traffic
// compared against a minutes-and-seconds behavioural model.
module tb_alarma;

  localparam int T_SONAR    = 60;
  localparam int T_POSPONER = 300;

  localparam int M_OFF   = 0;
  localparam int M_ARMED = 1;
  localparam int M_RING  = 2;
  localparam int M_SNZ   = 3;

  logic       reloj = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] c0 = 4'd0, c1 = 4'd0, c2 = 4'd0, c3 = 4'd0;
  logic       buttonalarma = 1'b0, pulm = 1'b0, pulh = 1'b0;
  logic       activar = 1'b0, snooze = 1'b0, tick_seg = 1'b0;
  logic [3:0] a0, a1, a2, a3;
  logic       sonando, pospuesta, buzzer;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: alarm as hours/minutes integers, ring phase with elapsed seconds.
  int m_st, m_el, m_hh, m_mm;
  bit m_bz, m_pm, m_ph, m_ps, m_prev;

  alarma #(.T_SONAR(T_SONAR), .T_POSPONER(T_POSPONER), .CNT_W(9)) dut (
    .reloj(reloj), .reset(reset),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .buttonalarma(buttonalarma), .pulm(pulm), .pulh(pulh),
    .activar(activar), .snooze(snooze), .tick_seg(tick_seg),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .sonando(sonando), .pospuesta(pospuesta), .buzzer(buzzer)
  );

  always #5 reloj = ~reloj;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] exp_a();
    return {4'(m_hh / 10), 4'(m_hh % 10), 4'(m_mm / 10), 4'(m_mm % 10)};
  endfunction

  function automatic logic [2:0] exp_out();
    return {m_st == M_RING, m_st == M_SNZ, (m_st == M_RING) && m_bz};
  endfunction

  task automatic model_reset();
    m_st = M_OFF; m_el = 0; m_bz = 1'b0;
    m_hh = 0; m_mm = 0;
    m_pm = 1'b0; m_ph = 1'b0; m_ps = 1'b0; m_prev = 1'b1;
  endtask

  // One clock: advance the model from pre-edge inputs, then sample #1 after the edge.
  task automatic step();
    bit em, eh, es, match, fire, bz;
    int cur, st, el, hh, mm;
    em = pulm && !m_pm;
    eh = pulh && !m_ph;
    es = snooze && !m_ps;
    cur = (int'(c3) * 10 + int'(c2)) * 60 + int'(c1) * 10 + int'(c0);
    match = (cur == m_hh * 60 + m_mm);
    fire = match && !m_prev && !buttonalarma;
    st = m_st; el = m_el; bz = m_bz; hh = m_hh; mm = m_mm;
    if (!activar) st = M_OFF;
    else begin
      case (m_st)
        M_OFF:   st = M_ARMED;
        M_ARMED: if (fire) begin st = M_RING; el = 0; bz = 1'b1; end
        M_RING: begin
          if (buttonalarma) st = M_ARMED;
          else if (es) begin st = M_SNZ; el = 0; end
          else if (tick_seg) begin
            el = el + 1; bz = !bz;
            if (el == T_SONAR) st = M_ARMED;
          end
        end
        default: begin
          if (buttonalarma) st = M_ARMED;
          else if (tick_seg) begin
            el = el + 1;
            if (el == T_POSPONER) begin st = M_RING; el = 0; bz = 1'b1; end
          end
        end
      endcase
    end
    if (buttonalarma) begin
      if (em) mm = (mm + 1) % 60;
      else if (eh) hh = (hh + 1) % 24;
    end
    @(posedge reloj);
    #1;
    m_st = st; m_el = el; m_bz = bz; m_hh = hh; m_mm = mm;
    m_prev = match; m_pm = pulm; m_ph = pulh; m_ps = snooze;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge reloj);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_time(input int hh, input int mm);
    c3 = 4'(hh / 10); c2 = 4'(hh % 10); c1 = 4'(mm / 10); c0 = 4'(mm % 10);
  endtask

  task automatic press_m();
    pulm = 1'b1; step(); pulm = 1'b0; step();
  endtask

  task automatic press_h();
    pulh = 1'b1; step(); pulh = 1'b0; step();
  endtask

  task automatic tick_once(input bit with_snooze);
    tick_seg = 1'b1;
    snooze = with_snooze;
    step();
    tick_seg = 1'b0;
    snooze = 1'b0;
    repeat ($urandom_range(0, 2)) step();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({a3, a2, a1, a0} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_alarm: got %h expected 0000", {a3, a2, a1, a0});
    end
    n_tests++;
    if ({sonando, pospuesta, buzzer} !== 3'b000) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 000", {sonando, pospuesta, buzzer});
    end
  endtask

  task automatic test_set();
    buttonalarma = 1'b1;
    repeat (5) press_m();
    repeat (7) press_h();
    n_tests++;
    if ({a3, a2, a1, a0} !== 16'h0705) begin
      n_fail++; $display("FAIL set_0705: got %h expected 0705", {a3, a2, a1, a0});
    end
    repeat (55) press_m();
    n_tests++;
    if ({a3, a2, a1, a0} !== 16'h0700) begin
      n_fail++; $display("FAIL minute_wrap: got %h expected 0700", {a3, a2, a1, a0});
    end
    repeat (16) press_h();
    n_tests++;
    if ({a3, a2, a1, a0} !== 16'h2300) begin
      n_fail++; $display("FAIL hour_23: got %h expected 2300", {a3, a2, a1, a0});
    end
    press_h();
    n_tests++;
    if ({a3, a2, a1, a0} !== 16'h0000) begin
      n_fail++; $display("FAIL hour_wrap: got %h expected 0000", {a3, a2, a1, a0});
    end
    repeat (23) press_h();
    n_tests++;
    if ({a3, a2, a1, a0} !== 16'h2300) begin
      n_fail++; $display("FAIL hour_recount: got %h expected 2300", {a3, a2, a1, a0});
    end
    pulm = 1'b1; pulh = 1'b1; step(); pulm = 1'b0; pulh = 1'b0; step();
    n_tests++;
    if ({a3, a2, a1, a0} !== 16'h2301) begin
      n_fail++; $display("FAIL both_buttons: got %h expected 2301", {a3, a2, a1, a0});
    end
    // Random presses with the mode level also toggling: model decides the outcome.
    for (int i = 0; i < 60; i++) begin
      buttonalarma = ($urandom_range(0, 3) != 0);
      pulm = $urandom_range(0, 1);
      pulh = $urandom_range(0, 1);
      step();
      n_tests++;
      if ({a3, a2, a1, a0} !== exp_a()) begin
        n_fail++; $display("FAIL set_random[%0d]: got %h expected %h", i, {a3, a2, a1, a0}, exp_a());
      end
    end
    pulm = 1'b0; pulh = 1'b0; buttonalarma = 1'b0;
    step();
  endtask

  task automatic test_ring();
    buttonalarma = 1'b1;
    do_reset();
    repeat (7) press_h();
    repeat (5) press_m();
    buttonalarma = 1'b0;
    set_time(7, 4);
    activar = 1'b1;
    repeat (3) step();
    n_tests++;
    if (sonando !== 1'b0) begin
      n_fail++; $display("FAIL ring_before_match: got %b expected 0", sonando);
    end
    set_time(7, 5);
    step();
    n_tests++;
    if ({sonando, buzzer} !== 2'b11) begin
      n_fail++; $display("FAIL ring_start: got %b expected 11", {sonando, buzzer});
    end
    for (int k = 1; k <= T_SONAR; k++) begin
      tick_once(1'b0);
      n_tests++;
      if (k < T_SONAR) begin
        if ({sonando, buzzer} !== {1'b1, (k % 2) == 0}) begin
          n_fail++; $display("FAIL ring_tick[%0d]: got %b expected %b", k, {sonando, buzzer}, {1'b1, (k % 2) == 0});
        end
      end else if ({sonando, pospuesta, buzzer} !== 3'b000) begin
        n_fail++; $display("FAIL ring_timeout: got %b expected 000", {sonando, pospuesta, buzzer});
      end
    end
    repeat (10) step();
    n_tests++;
    if (sonando !== 1'b0) begin
      n_fail++; $display("FAIL no_refire: got %b expected 0", sonando);
    end
  endtask

  task automatic test_snooze();
    set_time(7, 6); step();
    set_time(7, 5); step();
    n_tests++;
    if (sonando !== 1'b1) begin
      n_fail++; $display("FAIL snooze_ring: got %b expected 1", sonando);
    end
    repeat (3) tick_once(1'b0);
    snooze = 1'b1; step(); snooze = 1'b0;
    n_tests++;
    if ({sonando, pospuesta, buzzer} !== 3'b010) begin
      n_fail++; $display("FAIL snooze_enter: got %b expected 010", {sonando, pospuesta, buzzer});
    end
    step();
    for (int k = 1; k <= T_POSPONER; k++) begin
      tick_once(1'b0);
      n_tests++;
      if (k < T_POSPONER) begin
        if ({sonando, pospuesta, buzzer} !== 3'b010) begin
          n_fail++; $display("FAIL snooze_wait[%0d]: got %b expected 010", k, {sonando, pospuesta, buzzer});
        end
      end else if ({sonando, pospuesta, buzzer} !== 3'b101) begin
        n_fail++; $display("FAIL snooze_rering: got %b expected 101", {sonando, pospuesta, buzzer});
      end
    end
    repeat (T_SONAR - 1) tick_once(1'b0);
    n_tests++;
    if (sonando !== 1'b1) begin
      n_fail++; $display("FAIL rering_59: got %b expected 1", sonando);
    end
    tick_once(1'b1);
    n_tests++;
    if ({sonando, pospuesta} !== 2'b01) begin
      n_fail++; $display("FAIL snooze_beats_expiry: got %b expected 01", {sonando, pospuesta});
    end
  endtask

  task automatic test_abort();
    buttonalarma = 1'b1; step();
    n_tests++;
    if ({sonando, pospuesta} !== 2'b00) begin
      n_fail++; $display("FAIL set_mode_from_snooze: got %b expected 00", {sonando, pospuesta});
    end
    buttonalarma = 1'b0; step();
    set_time(7, 6); step();
    set_time(7, 5); step();
    activar = 1'b0; step();
    n_tests++;
    if ({sonando, buzzer} !== 2'b00) begin
      n_fail++; $display("FAIL activar_drop: got %b expected 00", {sonando, buzzer});
    end
    activar = 1'b1; step();
    set_time(7, 6); step();
    set_time(7, 5); step();
    n_tests++;
    if (sonando !== 1'b1) begin
      n_fail++; $display("FAIL rearm_ring: got %b expected 1", sonando);
    end
    buttonalarma = 1'b1; step();
    n_tests++;
    if ({sonando, pospuesta, buzzer} !== 3'b000) begin
      n_fail++; $display("FAIL set_mode_from_ring: got %b expected 000", {sonando, pospuesta, buzzer});
    end
    set_time(7, 6); step();
    press_m();
    buttonalarma = 1'b0;
    repeat (5) step();
    n_tests++;
    if ({sonando, a3, a2, a1, a0} !== {1'b0, 16'h0706}) begin
      n_fail++; $display("FAIL edit_no_fire: got %b/%h expected 0/0706", sonando, {a3, a2, a1, a0});
    end
  endtask

  task automatic test_reset_zero();
    set_time(0, 0);
    activar = 1'b1;
    buttonalarma = 1'b0;
    do_reset();
    repeat (5) step();
    n_tests++;
    if (sonando !== 1'b0) begin
      n_fail++; $display("FAIL reset_0000_no_ring: got %b expected 0", sonando);
    end
    buttonalarma = 1'b1; press_m(); buttonalarma = 1'b0;
    set_time(0, 1); step();
    n_tests++;
    if (sonando !== 1'b1) begin
      n_fail++; $display("FAIL ring_0001: got %b expected 1", sonando);
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({sonando, buzzer, a3, a2, a1, a0} !== 18'h0) begin
      n_fail++; $display("FAIL async_reset: got %b%b/%h expected 00/0000", sonando, buzzer, {a3, a2, a1, a0});
    end
    do_reset();
  endtask

  task automatic test_random();
    activar = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      buttonalarma = ($urandom_range(0, 19) == 0);
      pulm = ($urandom_range(0, 5) == 0);
      pulh = ($urandom_range(0, 5) == 0);
      snooze = ($urandom_range(0, 24) == 0);
      tick_seg = ($urandom_range(0, 2) == 0);
      activar = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) set_time(m_hh, m_mm);
        else set_time($urandom_range(0, 23), $urandom_range(0, 59));
      end
      step();
      n_tests++;
      if ({sonando, pospuesta, buzzer, a3, a2, a1, a0} !== {exp_out(), exp_a()}) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b/%h expected %b/%h", i, {sonando, pospuesta, buzzer},
                 {a3, a2, a1, a0}, exp_out(), exp_a());
      end
    end
    pulm = 1'b0; pulh = 1'b0; snooze = 1'b0; tick_seg = 1'b0; buttonalarma = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_set();
    test_ring();
    test_snooze();
    test_abort();
    test_reset_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
